// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the fetch stage: reset/handler addresses,
// legal instruction-memory window, exception codes, FSM states and the
// IF/ID register layout.
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Request/acknowledge instruction-memory bus between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_stage_if;

    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    modport master (output im_req, output im_addr, input im_ack, input im_rdata);
    modport slave  (input im_req, input im_addr, output im_ack, output im_rdata);

endinterface

// File: rtl/fetch_stage_pc_check.sv
// Combinational fetch-address legality test: word aligned and inside the
// instruction-memory window (unsigned compares).
module fetch_stage_pc_check
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_i,
    output logic        legal_o
);

    assign legal_o = (pc_i[1:0] == 2'b00) && (pc_i >= IM_LO) && (pc_i <= IM_HI);

endmodule

// File: rtl/fetch_stage.sv
// Fetch (F) stage: PC register, instruction-memory request/ack handshake
// and the IF/ID pipeline register feeding decode.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_D,
    input  logic [1:0]           PCsrc_D,
    input  logic [31:0]          npc_D,
    input  logic                 branch_D,
    input  logic                 eret_flush_D,
    input  logic [31:0]          epc,
    input  logic                 exc_req,
    fetch_stage_if.master        im_bus,
    output logic [31:0]          PC_D,
    output logic [31:0]          instr_D,
    output logic [4:0]           ExcCode_D,
    output logic                 BD_D
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    ifid_t        ifid_q, ifid_d;
    logic         redirectPend_q, redirectPend_d;
    logic [31:0]  redirectTgt_q, redirectTgt_d;
    logic         bdPend_q, bdPend_d;
    logic [31:0]  holdInstr_q, holdInstr_d;
    logic [31:0]  discardAddr_q, discardAddr_d;

    logic        legal;
    logic        imReq;
    logic        ackSeen;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        takeNpc;
    logic        advance;
    logic [31:0] seqPc;

    fetch_stage_pc_check u_pc_check (
        .pc_i    (pc_q),
        .legal_o (legal)
    );

    assign imReq           = ((state_q == FETCH) && legal) || (state_q == DISCARD);
    assign im_bus.im_req   = imReq;
    assign im_bus.im_addr  = (state_q == DISCARD) ? discardAddr_q : pc_q;
    assign ackSeen         = im_bus.im_ack && imReq;

    assign redirect   = exc_req || eret_flush_D;
    assign redirectPc = exc_req ? HANDLER_PC : epc;
    assign takeNpc    = (PCsrc_D != 2'b00) && !stall_D;
    assign advance    = !redirect && !stall_D &&
                        (((state_q == FETCH) && (!legal || ackSeen)) || (state_q == HOLD));
    assign seqPc      = takeNpc ? npc_D : (redirectPend_q ? redirectTgt_q : pc_q + 32'd4);

    assign PC_D      = ifid_q.pc;
    assign instr_D   = ifid_q.instr;
    assign ExcCode_D = ifid_q.exc;
    assign BD_D      = ifid_q.bd;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // FSM next state: a redirect parks in DISCARD only if a request is still unanswered
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = (imReq && !ackSeen) ? DISCARD : FETCH;
        end else begin
            case (state_q)
                FETCH:   if (legal && ackSeen && stall_D) state_d = HOLD;
                HOLD:    if (!stall_D) state_d = FETCH;
                DISCARD: if (ackSeen) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // FSM outputs: next PC, IF/ID contents, pending redirect and hold buffer
    always_comb begin
        pc_d           = pc_q;
        ifid_d         = ifid_q;
        redirectPend_d = redirectPend_q;
        redirectTgt_d  = redirectTgt_q;
        bdPend_d       = bdPend_q;
        holdInstr_d    = holdInstr_q;
        discardAddr_d  = discardAddr_q;
        if (redirect) begin
            pc_d           = redirectPc;
            ifid_d         = '{pc: pc_q, instr: 32'd0, exc: EXC_NONE, bd: 1'b0};
            redirectPend_d = 1'b0;
            bdPend_d       = 1'b0;
            holdInstr_d    = 32'd0;
            if (state_q != DISCARD) discardAddr_d = pc_q;
        end else if (advance) begin
            pc_d           = seqPc;
            redirectPend_d = 1'b0;
            bdPend_d       = 1'b0;
            ifid_d.pc      = pc_q;
            ifid_d.bd      = branch_D || bdPend_q;
            if (state_q == HOLD) begin
                ifid_d.instr = holdInstr_q;
                ifid_d.exc   = EXC_NONE;
            end else if (!legal) begin
                ifid_d.instr = 32'd0;
                ifid_d.exc   = EXC_ADEL;
            end else begin
                ifid_d.instr = im_bus.im_rdata;
                ifid_d.exc   = EXC_NONE;
            end
        end else begin
            // A branch that leaves D before its delay slot arrives is remembered
            // so the slot still gets BD_D and the target is not lost.
            if (takeNpc) begin
                redirectPend_d = 1'b1;
                redirectTgt_d  = npc_D;
            end
            if (branch_D && !stall_D) bdPend_d = 1'b1;
            if ((state_q == FETCH) && ackSeen && stall_D) holdInstr_d = im_bus.im_rdata;
            if (!stall_D) ifid_d = '{pc: pc_q, instr: 32'd0, exc: EXC_NONE, bd: 1'b0};
        end
    end

    // Datapath registers: PC, IF/ID, pending redirect and hold buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q           <= PC_RESET;
            ifid_q         <= '{pc: PC_RESET, instr: 32'd0, exc: EXC_NONE, bd: 1'b0};
            redirectPend_q <= 1'b0;
            redirectTgt_q  <= 32'd0;
            bdPend_q       <= 1'b0;
            holdInstr_q    <= 32'd0;
            discardAddr_q  <= PC_RESET;
        end else begin
            pc_q           <= pc_d;
            ifid_q         <= ifid_d;
            redirectPend_q <= redirectPend_d;
            redirectTgt_q  <= redirectTgt_d;
            bdPend_q       <= bdPend_d;
            holdInstr_q    <= holdInstr_d;
            discardAddr_q  <= discardAddr_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFetch_q;
    logic [31:0] perfStall_q;

    // Count real instruction deliveries and cycles where IF/ID holds or bubbles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perfFetch_q <= 32'd0;
            perfStall_q <= 32'd0;
        end else begin
            if (advance && ((state_q == HOLD) || legal)) perfFetch_q <= perfFetch_q + 32'd1;
            if (!redirect && !advance) perfStall_q <= perfStall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perfFetch_q;
    assign perf_stall_cnt = perfStall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID contents are queued when the
// stimulus for an edge is driven and popped/compared after that edge.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall_D;
    logic [1:0]  PCsrc_D;
    logic [31:0] npc_D;
    logic        branch_D;
    logic        eret_flush_D;
    logic [31:0] epc;
    logic        exc_req;
    logic        ack;
    logic [31:0] PC_D;
    logic [31:0] instr_D;
    logic [4:0]  ExcCode_D;
    logic        BD_D;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFetchCnt;
    logic [31:0] perfStallCnt;
`endif

    int checks = 0;
    int errors = 0;
    ifid_t expQ[$];

    fetch_stage_if bus ();

    // Instruction memory content is a fixed function of the address
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign bus.im_ack   = ack;
    assign bus.im_rdata = memWord(bus.im_addr);

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall_D      (stall_D),
        .PCsrc_D      (PCsrc_D),
        .npc_D        (npc_D),
        .branch_D     (branch_D),
        .eret_flush_D (eret_flush_D),
        .epc          (epc),
        .exc_req      (exc_req),
        .im_bus       (bus),
        .PC_D         (PC_D),
        .instr_D      (instr_D),
        .ExcCode_D    (ExcCode_D),
        .BD_D         (BD_D)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perfFetchCnt),
        .perf_stall_cnt (perfStallCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic st, input logic [1:0] src, input logic [31:0] npc,
                                 input logic br, input logic eret, input logic [31:0] epcv,
                                 input logic exc, input logic ackv);
        stall_D      = st;
        PCsrc_D      = src;
        npc_D        = npc;
        branch_D     = br;
        eret_flush_D = eret;
        epc          = epcv;
        exc_req      = exc;
        ack          = ackv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic pushIfid(input logic [31:0] pc, input logic [31:0] instr,
                            input logic [4:0] exc, input logic bd);
        ifid_t e;
        e.pc = pc; e.instr = instr; e.exc = exc; e.bd = bd;
        expQ.push_back(e);
    endtask

    task automatic checkIfid(input string tag);
        ifid_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, ".PC_D"}, PC_D, e.pc);
            checkOutput({tag, ".instr_D"}, instr_D, e.instr);
            checkOutput({tag, ".ExcCode_D"}, 32'(ExcCode_D), 32'(e.exc));
            checkOutput({tag, ".BD_D"}, 32'(BD_D), 32'(e.bd));
        end
    endtask

    task automatic checkBus(input string tag, input logic req, input logic [31:0] addr);
        checkOutput({tag, ".im_req"}, 32'(bus.im_req), 32'(req));
        if (req) checkOutput({tag, ".im_addr"}, bus.im_addr, addr);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        #12;
        // Reset state
        checkBus("reset", 1'b1, 32'h3000);
        pushIfid(32'h3000, 32'd0, EXC_NONE, 1'b0);
        checkIfid("reset");
        reset = 1'b1;

        // Back-to-back fetches with ack tied high
        ack = 1'b1;
        pushIfid(32'h3000, memWord(32'h3000), EXC_NONE, 1'b0);
        tick(); checkIfid("seq0"); checkBus("seq0", 1'b1, 32'h3004);
        pushIfid(32'h3004, memWord(32'h3004), EXC_NONE, 1'b0);
        tick(); checkIfid("seq1"); checkBus("seq1", 1'b1, 32'h3008);
        pushIfid(32'h3008, memWord(32'h3008), EXC_NONE, 1'b0);
        tick(); checkIfid("seq2"); checkBus("seq2", 1'b1, 32'h300C);

        // Asynchronous reset while a request is outstanding
        ack = 1'b0;
        reset = 1'b0;
        #1;
        checkBus("midreset", 1'b1, 32'h3000);
        pushIfid(32'h3000, 32'd0, EXC_NONE, 1'b0);
        checkIfid("midreset");
        reset = 1'b1;

        // Ack delayed two cycles at 0x3004
        ack = 1'b1;
        pushIfid(32'h3000, memWord(32'h3000), EXC_NONE, 1'b0);
        tick(); checkIfid("re0"); checkBus("re0", 1'b1, 32'h3004);
        ack = 1'b0;
        pushIfid(32'h3004, 32'd0, EXC_NONE, 1'b0);
        tick(); checkIfid("wait0"); checkBus("wait0", 1'b1, 32'h3004);
        pushIfid(32'h3004, 32'd0, EXC_NONE, 1'b0);
        tick(); checkIfid("wait1"); checkBus("wait1", 1'b1, 32'h3004);
        ack = 1'b1;
        pushIfid(32'h3004, memWord(32'h3004), EXC_NONE, 1'b0);
        tick(); checkIfid("late"); checkBus("late", 1'b1, 32'h3008);
        pushIfid(32'h3008, memWord(32'h3008), EXC_NONE, 1'b0);
        tick(); checkIfid("br_in"); checkBus("br_in", 1'b1, 32'h300C);

        // Taken branch in D, delay slot acknowledged late
        applyStimulus(1'b0, 2'b01, 32'h3100, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        pushIfid(32'h300C, 32'd0, EXC_NONE, 1'b0);
        tick(); checkIfid("ds_wait"); checkBus("ds_wait", 1'b1, 32'h300C);
        ack = 1'b1;
        pushIfid(32'h300C, memWord(32'h300C), EXC_NONE, 1'b1);
        tick(); checkIfid("ds"); checkBus("ds", 1'b1, 32'h3100);

        // Stall for three cycles while the ack arrives
        applyStimulus(1'b1, 2'b00, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            pushIfid(32'h300C, memWord(32'h300C), EXC_NONE, 1'b1);
            tick(); checkIfid("hold"); checkBus("hold", 1'b0, 32'h0);
        end
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        pushIfid(32'h3100, memWord(32'h3100), EXC_NONE, 1'b0);
        tick(); checkIfid("unhold"); checkBus("unhold", 1'b1, 32'h3104);

        // Exception while request at 0x3104 outstanding, stall ignored
        pushIfid(32'h3104, 32'd0, EXC_NONE, 1'b0);
        tick(); checkIfid("pre_exc"); checkBus("pre_exc", 1'b1, 32'h3104);
        applyStimulus(1'b1, 2'b00, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        pushIfid(32'h3104, 32'd0, EXC_NONE, 1'b0);
        tick(); checkIfid("exc"); checkBus("exc_discard", 1'b1, 32'h3104);
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        tick();
        checkOutput("discard_drop.instr_D", instr_D, 32'd0);
        checkBus("handler", 1'b1, 32'h4180);
        pushIfid(32'h4180, memWord(32'h4180), EXC_NONE, 1'b0);
        tick(); checkIfid("handler"); checkBus("handler1", 1'b1, 32'h4184);

        // Jump to misaligned then out-of-range targets
        applyStimulus(1'b0, 2'b01, 32'h3002, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        pushIfid(32'h4184, memWord(32'h4184), EXC_NONE, 1'b0);
        tick(); checkIfid("j_mis"); checkBus("mis_noreq", 1'b0, 32'h0);
        applyStimulus(1'b0, 2'b01, 32'h7000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        pushIfid(32'h3002, 32'd0, EXC_ADEL, 1'b0);
        tick(); checkIfid("adel_mis"); checkBus("hi_noreq", 1'b0, 32'h0);
        applyStimulus(1'b0, 2'b01, 32'h3200, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        pushIfid(32'h7000, 32'd0, EXC_ADEL, 1'b0);
        tick(); checkIfid("adel_hi"); checkBus("recover", 1'b1, 32'h3200);

        // ERET while request at 0x3200 outstanding
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b0, 1'b1, 32'h3300, 1'b0, 1'b0);
        pushIfid(32'h3200, 32'd0, EXC_NONE, 1'b0);
        tick(); checkIfid("eret"); checkBus("eret_discard", 1'b1, 32'h3200);
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        tick(); checkBus("discard_wait", 1'b1, 32'h3200);
        ack = 1'b1;
        tick(); checkBus("epc", 1'b1, 32'h3300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
